wts_i2s_transmitter: RTL and testbench

Output serializer for the wave-table sound core. It consumes the 12-bit left/right mixed samples that the channel mixer publishes once per `active` round, and converts them to signed 16-bit words. It transmits them as a standard Philips I2S stream (BCLK, LRCLK, SDATA) toward an external audio DAC. It sits after the channel mixer at the top of the cartridge/OCM build and holds the only double buffer between the mixer rate and the I2S frame rate.

---
 rtl/wts_pkg.sv | 22 ++
 rtl/wts_i2s_bclk_gen.sv | 43 ++++
 rtl/wts_i2s_transmitter.sv | 129 ++++++++++++
 tb/tb_wts_i2s_transmitter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wts_pkg.sv
// Shared constants and helpers for the wave-table sound core output path.
// Holds the I2S frame geometry and the 12-bit mixer to 16-bit DAC word conversion.
package wts_pkg;

  localparam int WTS_I2S_SLOTS = 32;
  localparam int WTS_I2S_WORD  = 16;

  localparam logic [2:0] WTS_MIX_UPDATE_SLOT = 3'd3;

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } wts_tx_state_e;

  // Offset-binary input only needs its MSB flipped to become two's complement.
  function automatic logic [15:0] wts_to_s16(input logic [11:0] x12, input logic offset_binary);
    logic [11:0] s12;
    s12 = offset_binary ? {~x12[11], x12[10:0]} : x12;
    return {s12, 4'b0000};
  endfunction

endpackage

// File: rtl/wts_i2s_bclk_gen.sv
// I2S bit-clock generator: divides clk down to BCLK and flags the falling-edge clk.
// The fe strobe is combinational and lines up with the clk on which BCLK drops.
module wts_i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fe
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;
  logic       bclk_q;
  logic       bclk_d;
  logic       tc;

  always_comb begin
    tc        = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q + 8'd1;
    bclk_d    = bclk_q;
    if (tc) begin
      div_cnt_d = 8'd0;
      bclk_d    = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 8'd0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign fe   = tc & bclk_q;

endmodule

// File: rtl/wts_i2s_transmitter.sv
// Philips I2S serializer for the mixed wave-table output, with a one-deep pending
// buffer decoupling the mixer update rate from the I2S frame rate.
module wts_i2s_transmitter
  import wts_pkg::*;
#(
  parameter bit          offset_binary = 1'b1,
  parameter int unsigned bclk_div      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  active,
  input  logic [11:0] left_in,
  input  logic [11:0] right_in,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        sample_fresh
);

  localparam int         SHIFT_W   = 2 * WTS_I2S_WORD;
  localparam logic [4:0] LAST_SLOT = 5'(WTS_I2S_SLOTS - 1);
  localparam logic [4:0] LR_FIRST  = 5'(WTS_I2S_WORD - 1);

  wts_tx_state_e state_q, state_d;

  logic [2:0]         prev_active_q, prev_active_d;
  logic [15:0]        left_pend_q, left_pend_d;
  logic [15:0]        right_pend_q, right_pend_d;
  logic               pending_new_q, pending_new_d;
  logic [4:0]         slot_q, slot_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               frame_start_q, frame_start_d;
  logic               sample_fresh_q, sample_fresh_d;

  logic fe;
  logic capture;
  logic load;

  wts_i2s_bclk_gen #(
    .BCLK_DIV(bclk_div)
  ) u_bclk_gen (
    .clk  (clk),
    .reset(reset),
    .bclk (i2s_bclk),
    .fe   (fe)
  );

  // A load reads the pending pair as it was before this clk, so a capture on the
  // same clk lands in the next frame and leaves pending_new set.
  always_comb begin
    state_d        = TX_RUN;
    prev_active_d  = active;
    left_pend_d    = left_pend_q;
    right_pend_d   = right_pend_q;
    pending_new_d  = pending_new_q;
    slot_d         = slot_q;
    shift_d        = shift_q;
    lrclk_d        = lrclk_q;
    sdata_d        = sdata_q;
    frame_start_d  = 1'b0;
    sample_fresh_d = sample_fresh_q;

    capture = (state_q == TX_RUN) &&
              (prev_active_q == WTS_MIX_UPDATE_SLOT) &&
              (active != WTS_MIX_UPDATE_SLOT);
    load    = fe && (slot_q == LAST_SLOT);

    if (load) begin
      pending_new_d = 1'b0;
    end
    if (capture) begin
      left_pend_d   = wts_to_s16(left_in, offset_binary);
      right_pend_d  = wts_to_s16(right_in, offset_binary);
      pending_new_d = 1'b1;
    end

    if (fe) begin
      slot_d = slot_q + 5'd1;
      if (load) begin
        shift_d        = mute ? '0 : {left_pend_q, right_pend_q};
        sample_fresh_d = pending_new_q;
        frame_start_d  = 1'b1;
      end else begin
        shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
      end
      sdata_d = shift_d[SHIFT_W-1];
      // Word select flips one BCLK ahead of the MSB of each word.
      lrclk_d = (slot_d >= LR_FIRST) && (slot_d != LAST_SLOT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= TX_IDLE;
      prev_active_q  <= 3'd0;
      left_pend_q    <= 16'h0000;
      right_pend_q   <= 16'h0000;
      pending_new_q  <= 1'b0;
      slot_q         <= LAST_SLOT;
      shift_q        <= '0;
      lrclk_q        <= 1'b0;
      sdata_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      sample_fresh_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_active_q  <= prev_active_d;
      left_pend_q    <= left_pend_d;
      right_pend_q   <= right_pend_d;
      pending_new_q  <= pending_new_d;
      slot_q         <= slot_d;
      shift_q        <= shift_d;
      lrclk_q        <= lrclk_d;
      sdata_q        <= sdata_d;
      frame_start_q  <= frame_start_d;
      sample_fresh_q <= sample_fresh_d;
    end
  end

  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign frame_start  = frame_start_q;
  assign sample_fresh = sample_fresh_q;

endmodule

// File: tb/tb_wts_i2s_transmitter.sv
// Scoreboard bench for the I2S transmitter: a clk-counting reference model queues
// expected frames, and a monitor reassembles serialized frames and compares them.
module tb_wts_i2s_transmitter;

  localparam int D          = 4;
  localparam int FRAME_CLKS = 64 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  active = 3'd0;
  logic [11:0] left_in = 12'h000;
  logic [11:0] right_in = 12'h000;
  logic        mute = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, sample_fresh;

  wts_i2s_transmitter #(
    .offset_binary(1'b1),
    .bclk_div     (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .left_in     (left_in),
    .right_in    (right_in),
    .mute        (mute),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .frame_start (frame_start),
    .sample_fresh(sample_fresh)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] bits;
    logic        fresh;
  } frame_t;

  frame_t      exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          frames_done = 0;

  int          n_edge = 0;
  int          first_fs = -1;
  logic [15:0] m_left = 16'h0000;
  logic [15:0] m_right = 16'h0000;
  logic        m_new = 1'b0;
  logic [2:0]  m_prev = 3'd0;

  int          idx = 32;
  logic        prev_bclk = 1'b0;
  logic [31:0] got_bits = 32'h0;
  logic [31:0] got_lr = 32'h0;
  frame_t      cur;

  // Signed sample value scaled by 16, i.e. the DAC word as a plain number.
  function automatic logic [15:0] ref_word(input logic [11:0] x);
    int v;
    v = (int'(x) - 2048) * 16;
    return 16'(v);
  endfunction

  function automatic bit is_load(input int n);
    return (n >= 2 * D) && (((n - 2 * D) % FRAME_CLKS) == 0);
  endfunction

  function automatic int slot_of(input int n);
    return ((n - 2 * D) / (2 * D)) % 32;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one clk worth of inputs and advances the reference model to the edge
  // that will consume them.
  task automatic applyStimulus(input logic rst, input logic [2:0] act,
                               input logic [11:0] l, input logic [11:0] r, input logic m);
    frame_t f;
    @(posedge clk);
    #2;
    if (!reset && frame_start && first_fs < 0) first_fs = n_edge;
    reset    = rst;
    active   = act;
    left_in  = l;
    right_in = r;
    mute     = m;
    if (rst) begin
      n_edge   = 0;
      m_left   = 16'h0000;
      m_right  = 16'h0000;
      m_new    = 1'b0;
      m_prev   = 3'd0;
      first_fs = -1;
      exp_q.delete();
    end else begin
      n_edge++;
      if (is_load(n_edge)) begin
        f.bits  = m ? 32'h0 : {m_left, m_right};
        f.fresh = m_new;
        exp_q.push_back(f);
        m_new = 1'b0;
      end
      if (m_prev == 3'd3 && act != 3'd3) begin
        m_left  = ref_word(l);
        m_right = ref_word(r);
        m_new   = 1'b1;
      end
      m_prev = act;
    end
  endtask

  // Monitor: on every BCLK fall collect one slot; a frame_start opens a new frame.
  always @(negedge clk) begin
    logic fe_seen;
    if (reset) begin
      idx       = 32;
      prev_bclk = 1'b0;
    end else begin
      fe_seen = prev_bclk && !i2s_bclk;
      if (frame_start) begin
        checkOutput("frame_start_on_fe", 32'(fe_seen), 32'd1);
        checkOutput("frame_start_after_32_slots", idx, 32);
        checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          checkOutput("sample_fresh", 32'(sample_fresh), 32'(cur.fresh));
          idx = 0;
        end else begin
          idx = 32;
        end
      end
      if (fe_seen && idx < 32) begin
        got_bits[31-idx] = i2s_sdata;
        got_lr[31-idx]   = i2s_lrclk;
        idx++;
        if (idx == 32) begin
          checkOutput("frame_bits", got_bits, cur.bits);
          checkOutput("lrclk_pattern", got_lr, 32'h0001_FFFE);
          frames_done++;
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  initial begin
    logic m_rand;
    bit   drained;
    m_rand = 1'b0;

    repeat (3) applyStimulus(1'b1, 3'd0, 12'h000, 12'h000, 1'b0);

    // Midscale input serializes as zeros; first load lands 2*D clks after release.
    for (int i = 0; i < FRAME_CLKS + 2 * D + 8; i++)
      applyStimulus(1'b0, 3'(i % 6), 12'h800, 12'h800, 1'b0);
    checkOutput("first_frame_start", 32'(first_fs), 32'(2 * D));

    // Full-scale extremes.
    for (int i = 0; i < FRAME_CLKS; i++)
      applyStimulus(1'b0, 3'(i % 6), 12'hFFF, 12'h000, 1'b0);

    // No captures: frames repeat with sample_fresh low.
    for (int i = 0; i < 3 * FRAME_CLKS; i++)
      applyStimulus(1'b0, 3'd0, 12'($urandom), 12'($urandom), 1'b0);

    // Capture coinciding with a load.
    while (!is_load(n_edge + 2))
      applyStimulus(1'b0, 3'd0, 12'h000, 12'h000, 1'b0);
    applyStimulus(1'b0, 3'd3, 12'h123, 12'h456, 1'b0);
    applyStimulus(1'b0, 3'd4, 12'h123, 12'h456, 1'b0);
    for (int i = 0; i < FRAME_CLKS + 8; i++)
      applyStimulus(1'b0, 3'd0, 12'h000, 12'h000, 1'b0);

    // Mute raised mid-frame at slot 7, held across one load, then released.
    while (n_edge < 2 * D || slot_of(n_edge) != 7)
      applyStimulus(1'b0, 3'($urandom_range(0, 5)), 12'($urandom), 12'($urandom), 1'b0);
    for (int i = 0; i < FRAME_CLKS; i++)
      applyStimulus(1'b0, 3'($urandom_range(0, 5)), 12'($urandom), 12'($urandom), 1'b1);
    for (int i = 0; i < 2 * FRAME_CLKS; i++)
      applyStimulus(1'b0, 3'($urandom_range(0, 5)), 12'($urandom), 12'($urandom), 1'b0);

    // Random traffic with occasional mute changes.
    for (int i = 0; i < 6 * FRAME_CLKS; i++) begin
      if ($urandom_range(0, 199) == 0) m_rand = ~m_rand;
      applyStimulus(1'b0, 3'($urandom_range(0, 5)), 12'($urandom), 12'($urandom), m_rand);
    end

    // Reset in the middle of a frame.
    while (slot_of(n_edge) != 20)
      applyStimulus(1'b0, 3'($urandom_range(0, 5)), 12'($urandom), 12'($urandom), 1'b0);
    applyStimulus(1'b1, 3'd0, 12'h000, 12'h000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("outputs_after_reset",
                {27'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, sample_fresh}, 32'd0);
    applyStimulus(1'b1, 3'd0, 12'h000, 12'h000, 1'b0);
    for (int i = 0; i < 2 * D + 4; i++)
      applyStimulus(1'b0, 3'd0, 12'($urandom), 12'($urandom), 1'b0);
    checkOutput("first_frame_start_after_reset", 32'(first_fs), 32'(2 * D));
    for (int i = 0; i < 2 * FRAME_CLKS; i++)
      applyStimulus(1'b0, 3'($urandom_range(0, 5)), 12'($urandom), 12'($urandom), 1'b0);

    // Stop in the gap between the last slot of a frame and the next load.
    drained = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      applyStimulus(1'b0, 3'd0, 12'h000, 12'h000, 1'b0);
      if (exp_q.size() == 0 && idx == 32) begin
        drained = 1'b1;
        break;
      end
    end
    checkOutput("scoreboard_drained", 32'(drained), 32'd1);
    checkOutput("enough_frames", 32'(frames_done >= 12), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
